// File: rtl/sfifo_rd_ctrl_if.sv
// rtl/sfifo_rd_ctrl_if.sv - FIFO read port and output stream bundle for the read controller
interface sfifo_rd_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  // FIFO read port
  logic                  sfifo_empty;
  logic                  sfifo_low_th;
  logic                  sfifo_valid;
  logic                  sfifo_ud;
  logic [DATA_WIDTH-1:0] sfifo_data;
  logic                  rd;

  // Downstream stream
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  // Controller side
  modport master (
    input  sfifo_empty,
    input  sfifo_low_th,
    input  sfifo_valid,
    input  sfifo_ud,
    input  sfifo_data,
    input  out_ready,
    output rd,
    output out_valid,
    output out_data
  );

  // FIFO plus consumer side
  modport slave (
    output sfifo_empty,
    output sfifo_low_th,
    output sfifo_valid,
    output sfifo_ud,
    output sfifo_data,
    output out_ready,
    input  rd,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/sfifo_rd_ctrl.sv
// rtl/sfifo_rd_ctrl.sv - FIFO read-side drain controller with 2-entry skid buffer
module sfifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sfifo_rd_ctrl_if.master      bus,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 drain_busy,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 err_ud,
  input  logic                 err_clr
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e                state_q;
  logic                  flush_pend_q;
  logic                  flush_done_q;
  logic                  drain_busy_q;
  logic                  rd_q;
  logic                  rd_d;

  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [1:0]            cnt_after_pop;
  logic                  pop;
  logic                  out_valid;
  logic                  capture;
  logic                  drop;
  logic [2:0]            occupancy;
  logic                  drain_exit;

  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic                  err_ud_q, err_ud_d;

  // Stream handshake and pop-issue decision; occupancy counts buffered plus in-flight words
  always_comb begin
    out_valid  = (buf_cnt_q != 2'd0);
    pop        = out_valid && bus.out_ready;
    occupancy  = {1'b0, buf_cnt_q} + {2'b00, rd_q} - {2'b00, pop};
    rd_d       = drain_busy_q && !bus.sfifo_empty && (occupancy < 3'd2);
    drain_exit = bus.sfifo_empty && !rd_q;
  end

  assign bus.rd        = rd_d;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? buf0_q : '0;
  assign flush_done    = flush_done_q;
  assign drain_busy    = drain_busy_q;
  assign word_cnt      = word_cnt_q;
  assign err_ud        = err_ud_q;

  // Drain FSM with registered busy/done outputs and the pending-flush latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      drain_busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          flush_done_q <= 1'b0;
          flush_pend_q <= flush_pend_q || flush;
          if (!bus.sfifo_low_th || flush || flush_pend_q) begin
            state_q      <= DRAIN;
            drain_busy_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_exit) begin
            state_q      <= IDLE;
            drain_busy_q <= 1'b0;
            flush_done_q <= flush_pend_q;
            // A flush landing on the exit cycle re-arms so the FSM drains again
            flush_pend_q <= flush;
          end else begin
            flush_done_q <= 1'b0;
            flush_pend_q <= flush_pend_q || flush;
          end
        end
        default: begin
          state_q      <= IDLE;
          drain_busy_q <= 1'b0;
          flush_done_q <= 1'b0;
        end
      endcase
    end
  end

  // One word can be in flight from the FIFO; track it so rd never overfills the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
    end
  end

  // Skid buffer next state: head at buf0, pop shifts down, capture goes to the first free slot
  always_comb begin
    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    cnt_after_pop = buf_cnt_q - {1'b0, pop};
    drop          = bus.sfifo_valid && (buf_cnt_q == 2'd2) && !pop;
    capture       = bus.sfifo_valid && !drop;
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (capture) begin
      if (cnt_after_pop == 2'd0) begin
        buf0_d = bus.sfifo_data;
      end else begin
        buf1_d = bus.sfifo_data;
      end
    end
    buf_cnt_d = cnt_after_pop + {1'b0, capture};
  end

  // Skid buffer storage; reset discards anything buffered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0_q    <= '0;
      buf1_q    <= '0;
      buf_cnt_q <= 2'd0;
    end else begin
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      buf_cnt_q <= buf_cnt_d;
    end
  end

  // Delivered-word counter (wraps) and sticky error; setting beats clearing
  always_comb begin
    word_cnt_d = word_cnt_q + CNT_WIDTH'(pop);
    if (bus.sfifo_ud || drop) begin
      err_ud_d = 1'b1;
    end else if (err_clr) begin
      err_ud_d = 1'b0;
    end else begin
      err_ud_d = err_ud_q;
    end
  end

  // Status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      err_ud_q   <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      err_ud_q   <= err_ud_d;
    end
  end

endmodule

// File: doc/sfifo_rd_ctrl.md
Name: sfifo_rd_ctrl

Overview:
Read-side controller for the synchronous FIFO (single-clock build, READ_EMPTY_EN and LOW_TH_SIGNAL enabled). It issues `rd` pops against `sfifo_empty`, absorbs the one-cycle read latency in a 2-entry skid buffer, and presents the words on a valid/ready stream. Draining starts once the FIFO rises above its low threshold, or on a flush request, and then runs until the FIFO is empty. It sits between the FIFO's read port and the downstream consumer.

Parameters:
DATA_WIDTH, 8, width of FIFO read data and stream data
CNT_WIDTH, 16, width of delivered-word counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
sfifo_empty  input  1  FIFO empty flag
sfifo_low_th  input  1  1 when FIFO level <= low threshold
sfifo_valid  input  1  FIFO read data valid, one cycle after an accepted rd
sfifo_ud  input  1  FIFO underflow pulse
sfifo_data  input  DATA_WIDTH  FIFO read data (FIFO data_out)
rd  output  1  FIFO pop request
out_valid  output  1  stream data valid
out_ready  input  1  stream consumer ready
out_data  output  DATA_WIDTH  stream data
flush  input  1  single-cycle request to drain FIFO completely
flush_done  output  1  one-cycle pulse when a flush completes
drain_busy  output  1  1 while in DRAIN state
word_cnt  output  CNT_WIDTH  words delivered (out_valid&&out_ready), wraps
err_ud  output  1  sticky underflow error
err_clr  input  1  clears err_ud

Behaviour:
- One clock, asynchronous active-low reset `rst_n`.
- Reset state:
  - state=IDLE; buffer empty; rd_q=0; flush_pend=0.
  - rd=0, out_valid=0, out_data=0, flush_done=0, drain_busy=0, word_cnt=0, err_ud=0.
- Reset mid-operation: any in-flight or buffered words are discarded.
- FSM, two states:
  - IDLE -> DRAIN when `!sfifo_low_th || flush || flush_pend`.
  - DRAIN -> IDLE when `sfifo_empty && !rd_q`. This gives hysteresis: draining continues below the threshold until the FIFO is empty.
  - On the DRAIN->IDLE edge with flush_pend=1: flush_done pulses 1 cycle and flush_pend clears.
- flush_pend:
  - Set by `flush` in any state.
  - A `flush` arriving on the same cycle as DRAIN->IDLE keeps flush_pend=1; the FSM re-enters DRAIN next cycle.
- rd (combinational): `rd = drain_busy && !sfifo_empty && (buf_cnt + rd_q - pop) < 2`, where `pop = out_valid && out_ready`.
  - This gives a combinational path out_ready -> rd.
  - rd is never asserted while sfifo_empty=1.
- rd_q: registered copy of rd, the number of words in flight (0/1).
- Capture: when sfifo_valid=1, write sfifo_data into the tail of a 2-entry buffer.
  - Capture and pop in the same cycle are legal.
  - The buffer never overflows by construction. If sfifo_valid arrives with buf_cnt=2 and no pop, drop the word and set err_ud.
- Stream output:
  - out_valid = (buf_cnt != 0); out_data = head entry.
  - out_data holds stable while out_valid && !out_ready.
  - out_data = 0 when the buffer is empty.
- Latency: rd in cycle N -> capture at end of N+1 -> out_valid in N+2.
  - Sustained throughput is 1 word/cycle with out_ready held high.
- word_cnt: +1 on each pop, modulo 2^CNT_WIDTH (0xFFFF -> 0x0000).
- err_ud: set on sfifo_ud or buffer drop; cleared by err_clr. Set wins over clear in the same cycle.
- FIFO going empty mid-burst: rd drops the same cycle; words in flight still arrive and are delivered; then DRAIN -> IDLE.

Test Plan:
- Reset: hold rst_n=0 with sfifo_low_th=0 and sfifo_empty=0 -> rd=0, out_valid=0, word_cnt=0, err_ud=0; release -> DRAIN next cycle and rd=1 the following cycle.
- Threshold start: FIFO preloaded 5..12 (8 words), low_th deasserts, out_ready=1 -> 8 consecutive rd cycles; out_data=5..12 on 8 consecutive cycles starting 2 cycles after the first rd; word_cnt=8; drain_busy returns 0 after empty.
- Backpressure: 4 words queued, out_ready=0 for 10 cycles -> rd issues exactly 2 pops then stops; out_data holds 5; on out_ready=1 the remaining words follow in order with no loss or duplication.
- Flush below threshold: 2 words (0xA1, 0xA2), low_th=1, pulse flush -> both words delivered; flush_done pulses once when DRAIN exits; flush while already empty -> flush_done 2 cycles later with no rd.
- Error and wrap: drive sfifo_ud=1 one cycle -> err_ud=1 sticky; err_clr with sfifo_ud simultaneous -> err_ud stays 1; err_clr alone -> 0; preset word_cnt 0xFFFF via 65535 pops, one more pop -> 0x0000.
